// File: rtl/matrix_input_parser_if.sv
// Byte-stream input and matrix-write output bundle of matrix_input_parser.
// The master modport is the parser; the slave modport is its environment.
interface matrix_input_parser_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic                  en;
    logic                  clear;
    logic [7:0]            rx_byte;
    logic                  rx_valid;
    logic [2:0]            dim_m;
    logic [2:0]            dim_n;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  parse_done;
    logic                  parse_error;
    logic [1:0]            err_code;
    logic                  busy;

    modport master (
        input  en, clear, rx_byte, rx_valid,
        output dim_m, dim_n, wr_en, wr_addr, wr_data,
        output parse_done, parse_error, err_code, busy
    );

    modport slave (
        output en, clear, rx_byte, rx_valid,
        input  dim_m, dim_n, wr_en, wr_addr, wr_data,
        input  parse_done, parse_error, err_code, busy
    );
endinterface

// File: rtl/matrix_input_parser.sv
// Tokenises an ASCII decimal byte stream into matrix dims m, n and m*n
// row-major element writes, reporting completion or a coded rejection.
module matrix_input_parser #(
    parameter int MAX_DIM    = 5,
    parameter int ELEM_MAX   = 9,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(MAX_DIM*MAX_DIM)
) (
    input  logic clk,
    input  logic rst_n,
    matrix_input_parser_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_M, S_N, S_ELEM, S_DONE, S_ERR} state_t;

    state_t                state_q, state_n;
    logic [DATA_WIDTH-1:0] acc_q, acc_n;
    logic                  tok_q, tok_n;
    logic                  ovf_q, ovf_n;
    logic [ADDR_WIDTH-1:0] count_q, count_n;
    logic [2:0]            dim_m_q, dim_m_n;
    logic [2:0]            dim_n_q, dim_n_n;
    logic                  wr_en_q, wr_en_n;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_n;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_n;
    logic                  done_q, done_n;
    logic                  error_q, error_n;
    logic [1:0]            err_q, err_n;

    logic                  is_digit, is_delim;
    logic [DATA_WIDTH:0]   step;
    logic [ADDR_WIDTH:0]   total, count_inc;

    // Returns {overflow, acc*10+digit clamped to all-ones}.
    function automatic logic [DATA_WIDTH:0] acc_step(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [3:0] d);
        logic [DATA_WIDTH+3:0] wide;
        wide = (DATA_WIDTH+4)'(a) * (DATA_WIDTH+4)'(10) + (DATA_WIDTH+4)'(d);
        if (wide > (DATA_WIDTH+4)'({DATA_WIDTH{1'b1}}))
            acc_step = {1'b1, {DATA_WIDTH{1'b1}}};
        else
            acc_step = {1'b0, wide[DATA_WIDTH-1:0]};
    endfunction

    assign is_digit  = (bus.rx_byte >= 8'h30) && (bus.rx_byte <= 8'h39);
    assign is_delim  = (bus.rx_byte == 8'h20) || (bus.rx_byte == 8'h0D) ||
                       (bus.rx_byte == 8'h0A) || (bus.rx_byte == 8'h2C);
    assign step      = acc_step(acc_q, bus.rx_byte[3:0]);
    assign total     = (ADDR_WIDTH+1)'(dim_m_q) * (ADDR_WIDTH+1)'(dim_n_q);
    assign count_inc = (ADDR_WIDTH+1)'(count_q) + (ADDR_WIDTH+1)'(1);

    always_comb begin
        state_n   = state_q;
        acc_n     = acc_q;
        tok_n     = tok_q;
        ovf_n     = ovf_q;
        count_n   = count_q;
        dim_m_n   = dim_m_q;
        dim_n_n   = dim_n_q;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr_q;
        wr_data_n = wr_data_q;
        error_n   = 1'b0;
        err_n     = err_q;
        // The final write is already on the bus while the state reads S_DONE.
        done_n    = wr_en_q && (state_q == S_DONE) && !bus.clear;

        if (bus.clear || state_q == S_IDLE) begin
            acc_n = '0;
            tok_n = 1'b0;
            ovf_n = 1'b0;
            if (bus.en) begin
                state_n = S_M;
                err_n   = 2'd0;
                dim_m_n = 3'd0;
                dim_n_n = 3'd0;
                count_n = '0;
            end else begin
                state_n = S_IDLE;
            end
        end else begin
            case (state_q)
                S_M, S_N, S_ELEM: begin
                    if (!bus.en) begin
                        state_n = S_IDLE;
                    end else if (bus.rx_valid) begin
                        if (is_digit) begin
                            acc_n = step[DATA_WIDTH-1:0];
                            ovf_n = ovf_q | step[DATA_WIDTH];
                            tok_n = 1'b1;
                        end else if (is_delim) begin
                            if (tok_q) begin
                                acc_n = '0;
                                tok_n = 1'b0;
                                ovf_n = 1'b0;
                                if (state_q == S_ELEM) begin
                                    if (!ovf_q && acc_q <= DATA_WIDTH'(ELEM_MAX)) begin
                                        wr_en_n   = 1'b1;
                                        wr_addr_n = count_q;
                                        wr_data_n = acc_q;
                                        count_n   = count_q + ADDR_WIDTH'(1);
                                        if (count_inc == total) state_n = S_DONE;
                                    end else begin
                                        state_n = S_ERR;
                                        error_n = 1'b1;
                                        err_n   = 2'd3;
                                    end
                                end else if (!ovf_q && acc_q >= DATA_WIDTH'(1) &&
                                             acc_q <= DATA_WIDTH'(MAX_DIM)) begin
                                    if (state_q == S_M) begin
                                        dim_m_n = acc_q[2:0];
                                        state_n = S_N;
                                    end else begin
                                        dim_n_n = acc_q[2:0];
                                        state_n = S_ELEM;
                                    end
                                end else begin
                                    state_n = S_ERR;
                                    error_n = 1'b1;
                                    err_n   = 2'd2;
                                end
                            end
                        end else begin
                            state_n = S_ERR;
                            error_n = 1'b1;
                            err_n   = 2'd1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (!bus.en) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            tok_q     <= 1'b0;
            ovf_q     <= 1'b0;
            count_q   <= '0;
            dim_m_q   <= 3'd0;
            dim_n_q   <= 3'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_q     <= 2'd0;
        end else begin
            state_q   <= state_n;
            acc_q     <= acc_n;
            tok_q     <= tok_n;
            ovf_q     <= ovf_n;
            count_q   <= count_n;
            dim_m_q   <= dim_m_n;
            dim_n_q   <= dim_n_n;
            wr_en_q   <= wr_en_n;
            wr_addr_q <= wr_addr_n;
            wr_data_q <= wr_data_n;
            done_q    <= done_n;
            error_q   <= error_n;
            err_q     <= err_n;
        end
    end

    assign bus.dim_m       = dim_m_q;
    assign bus.dim_n       = dim_n_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.parse_done  = done_q;
    assign bus.parse_error = error_q;
    assign bus.err_code    = err_q;
    assign bus.busy        = (state_q == S_M) || (state_q == S_N) || (state_q == S_ELEM);
endmodule

// File: doc/matrix_input_parser.md
Name: matrix_input_parser

Overview:
- Upstream of the matrix storage and ALU; sits between uart_rx and main_fsm.
- Consumes the received UART byte stream (rx_byte/rx_valid), tokenises ASCII decimal numbers and extracts matrix dimensions m, n followed by m*n elements.
- Issues row-major element writes to matrix storage.
- Pulses parse_done, which drives main_fsm input_done, or parse_error with an error code, which drives the error LED and countdown.

Parameters:
- MAX_DIM, 5, largest legal m or n; legal dimensions are 1..MAX_DIM.
- ELEM_MAX, 9, largest legal element value; legal elements are 0..ELEM_MAX.
- DATA_WIDTH, 8, width of the element data output and of the token accumulator.
- ADDR_WIDTH, $clog2(MAX_DIM*MAX_DIM), width of the linear element index.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  input  1  parse enable, high while main_fsm is in its input state.
- clear  input  1  synchronous abort/restart pulse (logical reset button).
- rx_byte  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_byte is valid this cycle.
- dim_m  output  3  latched row count.
- dim_n  output  3  latched column count.
- wr_en  output  1  one-cycle element write strobe.
- wr_addr  output  ADDR_WIDTH  row-major index, row*dim_n + col.
- wr_data  output  DATA_WIDTH  element value.
- parse_done  output  1  one-cycle pulse: matrix fully received.
- parse_error  output  1  one-cycle pulse: stream rejected.
- err_code  output  2  0 none, 1 illegal char, 2 dim out of range, 3 element out of range; held until next start.
- busy  output  1  high in S_M, S_N, S_ELEM.

Behaviour:
- Reset (rst_n low at a clock edge): all outputs 0, state S_IDLE, accumulator, token flag and counters cleared.
- States: S_IDLE, S_M, S_N, S_ELEM, S_DONE, S_ERR.
- S_IDLE -> S_M when en=1. On entry to S_M: err_code, dim_m, dim_n, element count and accumulator cleared.
- Byte classes, evaluated only when rx_valid=1:
  - Digit 0x30-0x39: acc = acc*10 + digit; token flag set. acc saturates at 2^DATA_WIDTH-1, and saturation counts as out-of-range.
  - Delimiter 0x20, 0x0D, 0x0A, 0x2C: if the token flag is set, the token terminates. Otherwise the byte is ignored, so runs of delimiters are legal.
  - Any other byte: S_ERR with err_code=1.
- Token termination clears acc and the token flag in the same cycle.
- S_M: value in 1..MAX_DIM -> latch dim_m, go to S_N. Otherwise S_ERR with err_code=2.
- S_N: same range check -> latch dim_n, go to S_ELEM. Otherwise S_ERR with err_code=2.
- S_ELEM: value <= ELEM_MAX -> wr_en=1, wr_addr=count, wr_data=value; count increments. Otherwise S_ERR with err_code=3 and no write.
  - If count reaches dim_m*dim_n with this write, go to S_DONE.
- Latency:
  - wr_en is registered and asserted the cycle after the rx_valid carrying the terminating delimiter.
  - parse_done pulses one cycle after the final wr_en.
  - parse_error pulses the cycle after the offending rx_valid.
- A digit run with no trailing delimiter never terminates. The block waits indefinitely; there is no timeout in this block.
- S_DONE and S_ERR: all bytes ignored and no writes. When en drops, return to S_IDLE; dim_m, dim_n and err_code remain readable.
- en low in S_M, S_N or S_ELEM: abort to S_IDLE. No done or error pulse; partial writes are not undone.
- clear=1 in any state: go to S_IDLE if en=0, or to S_M (fresh start) if en=1. A simultaneous rx_valid is discarded, because clear has priority.
- rst_n has priority over clear.
- dim_m*dim_n is computed from the latched dims; the maximum is MAX_DIM^2 = 25, which fits ADDR_WIDTH.

Test Plan:
- en=1, bytes "2 3 1 2 3 4 5 6\n" -> six wr_en pulses: addr 0..5, data 1..6. dim_m=2, dim_n=3. One parse_done one cycle after the addr=5 write. parse_error never asserted.
- "6 " -> parse_error, err_code=2, no writes. "0 " likewise gives err_code=2.
- "1 1 12 " (ELEM_MAX=9) -> dims 1/1, no write, parse_error with err_code=3. "1 1 999 " also gives err_code=3 via saturation.
- "2 a" -> parse_error, err_code=1, dim_m=2 retained.
- "\r\n 1,,  2\r\n7  8 \n" -> dims 1/2, writes (0,7) and (1,8), parse_done.
- Abort and gating cases:
  - After "2 2 5 ", pulse clear with en=1, then send "1 1 4 " -> single write (0,4), dims 1/1, parse_done.
  - With en=0, any bytes -> no outputs change.
  - rst_n low mid-stream -> all outputs 0 on the next edge.
